// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one data memory between the CPU data port (C) and a
// secondary requester (D). One transaction is in flight at a time; each requester stalls until its own completes.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              C_READ,
    input  logic              C_WRITE,
    input  logic [ADDR_W-1:0] C_ADDRESS,
    input  logic [DATA_W-1:0] C_WRITE_DATA,
    output logic [DATA_W-1:0] C_READ_DATA,
    output logic              C_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITE_DATA,
    output logic [DATA_W-1:0] D_READ_DATA,
    output logic              D_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDRESS,
    output logic [DATA_W-1:0] M_WRITE_DATA,
    input  logic [DATA_W-1:0] M_READ_DATA,
    input  logic              M_BUSYWAIT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic              cmd_rd_q, cmd_rd_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0] rdata_c_q, rdata_c_d;
    logic [DATA_W-1:0] rdata_d_q, rdata_d_d;

    logic req_c_s;
    logic req_d_s;
    logic grant_s;
    logic done_c_s;
    logic done_d_s;

    assign req_c_s = C_READ | C_WRITE;
    assign req_d_s = D_READ | D_WRITE;

    // Next-state logic: grant, memory handshake and per-port read-data capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_c_d   = rdata_c_q;
        rdata_d_d   = rdata_d_q;
        grant_s     = PORT_C;

        case (state_q)
            ST_IDLE: begin
                if (req_c_s | req_d_s) begin
                    grant_s = (req_c_s & req_d_s) ? prio_q : req_d_s;
                    owner_d = grant_s;
                    state_d = ST_BUSY;
                    // A write wins when both strobes of the same port are high
                    if (grant_s == PORT_D) begin
                        cmd_wr_d    = D_WRITE;
                        cmd_rd_d    = D_READ & ~D_WRITE;
                        cmd_addr_d  = D_ADDRESS;
                        cmd_wdata_d = D_WRITE_DATA;
                    end else begin
                        cmd_wr_d    = C_WRITE;
                        cmd_rd_d    = C_READ & ~C_WRITE;
                        cmd_addr_d  = C_ADDRESS;
                        cmd_wdata_d = C_WRITE_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!M_BUSYWAIT) begin
                    if (cmd_rd_q && (owner_q == PORT_D)) begin
                        rdata_d_d = M_READ_DATA;
                    end else if (cmd_rd_q) begin
                        rdata_c_d = M_READ_DATA;
                    end else begin
                        rdata_c_d = rdata_c_q;
                    end
                    cmd_rd_d = 1'b0;
                    cmd_wr_d = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                prio_d  = ~owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                cmd_rd_d = 1'b0;
                cmd_wr_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and command registers; reset abandons any transaction in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            owner_q     <= PORT_C;
            prio_q      <= PORT_C;
            cmd_rd_q    <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= {ADDR_W{1'b0}};
            cmd_wdata_q <= {DATA_W{1'b0}};
            rdata_c_q   <= {DATA_W{1'b0}};
            rdata_d_q   <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_c_q   <= rdata_c_d;
            rdata_d_q   <= rdata_d_d;
        end
    end

    // The strobe registers are cleared at completion, so they are low outside BUSY
    assign M_READ       = cmd_rd_q;
    assign M_WRITE      = cmd_wr_q;
    assign M_ADDRESS    = cmd_addr_q;
    assign M_WRITE_DATA = cmd_wdata_q;

    assign C_READ_DATA  = rdata_c_q;
    assign D_READ_DATA  = rdata_d_q;

    assign done_c_s   = ~RESET & (state_q == ST_DONE) & (owner_q == PORT_C);
    assign done_d_s   = ~RESET & (state_q == ST_DONE) & (owner_q == PORT_D);
    assign C_BUSYWAIT = req_c_s & ~done_c_s;
    assign D_BUSYWAIT = req_d_s & ~done_d_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for dmem_arbiter: a vector table of single-port transactions
// followed by hand-written sequences for contention, fairness and mid-transaction reset.
module tb_dmem_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       C_READ = 1'b0, C_WRITE = 1'b0;
    logic [7:0] C_ADDRESS = 8'h00, C_WRITE_DATA = 8'h00;
    logic [7:0] C_READ_DATA;
    logic       C_BUSYWAIT;
    logic       D_READ = 1'b0, D_WRITE = 1'b0;
    logic [7:0] D_ADDRESS = 8'h00, D_WRITE_DATA = 8'h00;
    logic [7:0] D_READ_DATA;
    logic       D_BUSYWAIT;
    logic       M_READ, M_WRITE;
    logic [7:0] M_ADDRESS, M_WRITE_DATA, M_READ_DATA;
    logic       M_BUSYWAIT;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .C_READ(C_READ), .C_WRITE(C_WRITE), .C_ADDRESS(C_ADDRESS),
        .C_WRITE_DATA(C_WRITE_DATA), .C_READ_DATA(C_READ_DATA), .C_BUSYWAIT(C_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS),
        .D_WRITE_DATA(D_WRITE_DATA), .D_READ_DATA(D_READ_DATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS),
        .M_WRITE_DATA(M_WRITE_DATA), .M_READ_DATA(M_READ_DATA), .M_BUSYWAIT(M_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory model: stalls for mem_wait cycles after a strobe rises, then completes
    logic [7:0] mem [0:255];
    bit         mem_ready = 1'b0;
    int         mem_wait = 0;
    int         mem_cnt = 0;

    assign M_BUSYWAIT  = (M_READ | M_WRITE) && (mem_cnt < mem_wait);
    assign M_READ_DATA = mem[M_ADDRESS];

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'h5A;
            mem[8'h20] <= 8'hA7;
            mem[8'h40] <= 8'h9C;
            mem_ready  <= 1'b1;
        end else if (M_READ | M_WRITE) begin
            if (mem_cnt >= mem_wait) begin
                if (M_WRITE) mem[M_ADDRESS] <= M_WRITE_DATA;
                mem_cnt <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // The memory must never see both strobes at once
    always @(negedge CLK) begin
        if (!RESET && (M_READ | M_WRITE)) begin
            checks++;
            if (M_READ && M_WRITE) begin
                errors++;
                $display("FAIL strobe_overlap: M_READ=%0b M_WRITE=%0b required not both high", M_READ, M_WRITE);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        C_READ = 1'b0; C_WRITE = 1'b0;
        D_READ = 1'b0; D_WRITE = 1'b0;
    endtask

    task automatic drive(input bit port, input bit rd, input bit wr,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (port) begin
            D_READ = rd; D_WRITE = wr; D_ADDRESS = addr; D_WRITE_DATA = wdata;
        end else begin
            C_READ = rd; C_WRITE = wr; C_ADDRESS = addr; C_WRITE_DATA = wdata;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    typedef struct {
        bit         port;   // 0 = C, 1 = D
        bit         rd;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         nwait;
        logic [7:0] exp_c;
        logic [7:0] exp_d;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    vec_t v;
    int   lat, strb, c_done, d_done, n;
    bit   d_stall_ok;
    logic [5:0] order;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 2, 8'h5A, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 0, 8'h5A, 8'hA7};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h20, 8'h11, 1, 8'h5A, 8'hA7};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1, 8'h5A, 8'h11};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h30, 8'h77, 0, 8'h5A, 8'h11};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 3, 8'h77, 8'h11};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h77, 8'h5A};

        // Reset state, with port C requesting while reset is held
        clear_inputs();
        tick();
        tick();
        C_READ = 1'b1;
        #1;
        check("rst_c_busywait", C_BUSYWAIT, 1'b1);
        check("rst_d_busywait", D_BUSYWAIT, 1'b0);
        check("rst_m_read", M_READ, 1'b0);
        check("rst_m_write", M_WRITE, 1'b0);
        check("rst_m_address", M_ADDRESS, 8'h00);
        check("rst_m_wdata", M_WRITE_DATA, 8'h00);
        check("rst_c_rdata", C_READ_DATA, 8'h00);
        check("rst_d_rdata", D_READ_DATA, 8'h00);
        do_reset();

        // Table of single-port transactions
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            mem_wait = v.nwait;
            drive(v.port, v.rd, v.wr, v.addr, v.wdata);
            lat = -1;
            strb = 0;
            for (int c = 0; c < 40; c++) begin
                #1;
                if (c == 1) begin
                    check("vec_m_read", M_READ, v.rd & ~v.wr);
                    check("vec_m_write", M_WRITE, v.wr);
                    check("vec_m_address", M_ADDRESS, v.addr);
                    if (v.wr) check("vec_m_wdata", M_WRITE_DATA, v.wdata);
                end
                if (M_READ | M_WRITE) strb++;
                if (!(v.port ? D_BUSYWAIT : C_BUSYWAIT)) begin
                    lat = c;
                    break;
                end
                tick();
            end
            check("vec_latency", lat, 2 + v.nwait);
            check("vec_strobe_cycles", strb, 1 + v.nwait);
            check("vec_c_rdata", C_READ_DATA, v.exp_c);
            check("vec_d_rdata", D_READ_DATA, v.exp_d);
            check("vec_other_busywait", v.port ? C_BUSYWAIT : D_BUSYWAIT, 1'b0);
            clear_inputs();
            tick();
        end

        // Simultaneous requests after reset: C writes 0x33 to 0x04, D reads it back
        do_reset();
        mem_wait = 1;
        C_WRITE = 1'b1; C_ADDRESS = 8'h04; C_WRITE_DATA = 8'h33;
        D_READ = 1'b1;  D_ADDRESS = 8'h04;
        c_done = -1; d_done = -1; d_stall_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c_done < 0 && !D_BUSYWAIT) d_stall_ok = 1'b0;
            if (c_done < 0 && C_WRITE && !C_BUSYWAIT) begin
                c_done = c;
                C_WRITE = 1'b0;
            end
            if (D_READ && !D_BUSYWAIT) begin
                d_done = c;
                break;
            end
            tick();
        end
        check("sim_c_done_cycle", c_done, 3);
        check("sim_d_done_cycle", d_done, 7);
        check("sim_d_stalled", d_stall_ok, 1'b1);
        check("sim_d_rdata", D_READ_DATA, 8'h33);
        clear_inputs();
        tick();

        // Fairness: both ports request continuously; C must lead since prio returned to C
        mem_wait = 0;
        C_READ = 1'b1; C_ADDRESS = 8'h10;
        D_READ = 1'b1; D_ADDRESS = 8'h20;
        n = 0;
        order = 6'b000000;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (!C_BUSYWAIT) begin
                order[n] = 1'b0;
                n++;
            end else if (!D_BUSYWAIT) begin
                order[n] = 1'b1;
                n++;
            end
            if (n == 6) break;
            tick();
        end
        check("fair_count", n, 6);
        for (int i = 0; i < 6; i++) check("fair_grant", order[i], i % 2);
        check("fair_c_rdata", C_READ_DATA, 8'h5A);
        clear_inputs();
        tick();

        // Reset pulsed in the second BUSY cycle of a C read
        mem_wait = 3;
        C_READ = 1'b1; C_ADDRESS = 8'h40;
        tick();
        check("rmb_busy1_m_read", M_READ, 1'b1);
        tick();
        RESET = 1'b1;
        tick();
        check("rmb_m_read", M_READ, 1'b0);
        check("rmb_c_rdata", C_READ_DATA, 8'h00);
        check("rmb_c_busywait", C_BUSYWAIT, 1'b1);
        RESET = 1'b0;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c == 1) check("rmb_regrant_m_read", M_READ, 1'b1);
            if (!C_BUSYWAIT) begin
                lat = c;
                break;
            end
            tick();
        end
        check("rmb_latency", lat, 5);
        check("rmb_c_rdata_after", C_READ_DATA, 8'h9C);
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
